hood_output_driver: RTL and testbench

- Consumer end of the range-hood controller's mode interface: takes `mode`, `countdown` and `cleaning_reminder` and drives the physical actuators.
- Actuators driven: fan PWM with soft duty ramping, gear/status LEDs, a blinking countdown LED, and a 3-beep buzzer alert on a new cleaning reminder.
- Sits between the mode controller and the board I/O; one clock domain.

---
 rtl/hood_output_driver.sv | 237 +++++++++++++++++++++++
 tb/tb_hood_output_driver.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hood_output_driver.sv
`default_nettype none
// ============================================================================
// Module   : hood_output_driver
// Brief    : Range-hood actuator driver: ramped fan PWM, gear/status LEDs,
//            blinking countdown LED and a multi-beep cleaning-reminder buzzer.
// Revision : 1.0 - initial release
// ============================================================================
module hood_output_driver #(
    parameter int         PWM_PRESCALE = 4,
    parameter int         RAMP_TICK    = 100000,
    parameter logic [7:0] DUTY_1       = 8'd85,
    parameter logic [7:0] DUTY_2       = 8'd170,
    parameter logic [7:0] DUTY_3       = 8'd255,
    parameter logic [7:0] DUTY_CLEAN   = 8'd128,
    parameter int         BLINK_HALF   = 50000000,
    parameter int         TONE_HALF    = 25000,
    parameter int         BEEP_ON      = 20000000,
    parameter int         BEEP_OFF     = 20000000,
    parameter int         BEEP_COUNT   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power_state,
    input  logic [2:0] mode,
    input  logic       countdown,
    input  logic       cleaning_reminder,
    output logic       fan_pwm,
    output logic [7:0] fan_duty,
    output logic [3:0] gear_led,
    output logic       countdown_led,
    output logic       remind_led,
    output logic       buzzer,
    output logic       mode_err
);

    localparam int c_PRE_W   = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam int c_RAMP_W  = (RAMP_TICK > 1)    ? $clog2(RAMP_TICK)    : 1;
    localparam int c_BLINK_W = (BLINK_HALF > 1)   ? $clog2(BLINK_HALF)   : 1;
    localparam int c_TONE_W  = (TONE_HALF > 1)    ? $clog2(TONE_HALF)    : 1;
    localparam int c_TMR_MAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
    localparam int c_TMR_W   = (c_TMR_MAX > 1)    ? $clog2(c_TMR_MAX)    : 1;
    localparam int c_BN_W    = $clog2(BEEP_COUNT + 1);

    localparam logic [c_PRE_W-1:0]   c_PRE_LAST   = c_PRE_W'(PWM_PRESCALE - 1);
    localparam logic [c_RAMP_W-1:0]  c_RAMP_LAST  = c_RAMP_W'(RAMP_TICK - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_HALF - 1);
    localparam logic [c_TONE_W-1:0]  c_TONE_LAST  = c_TONE_W'(TONE_HALF - 1);
    localparam logic [c_TMR_W-1:0]   c_ON_LAST    = c_TMR_W'(BEEP_ON - 1);
    localparam logic [c_TMR_W-1:0]   c_OFF_LAST   = c_TMR_W'(BEEP_OFF - 1);
    localparam logic [c_BN_W-1:0]    c_BEEP_TOT   = c_BN_W'(BEEP_COUNT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    logic                 w_clr;
    logic [7:0]           w_target;
    logic [3:0]           w_gear;
    logic                 w_illegal;
    logic                 w_rise;

    logic [7:0]           r_duty;
    logic [c_RAMP_W-1:0]  r_ramp_cnt;
    logic [c_PRE_W-1:0]   r_pre_cnt;
    logic [7:0]           r_pwm_cnt;
    logic                 r_fan_pwm;
    logic [3:0]           r_gear_led;
    logic                 r_mode_err;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_phase;
    logic                 r_cd_led;
    logic                 r_rem_q;

    state_t               r_state,  w_state_nxt;
    logic [c_BN_W-1:0]    r_beep_n, w_beep_n_nxt;
    logic [c_TMR_W-1:0]   r_tmr,    w_tmr_nxt;
    logic [c_TONE_W-1:0]  r_tone,   w_tone_nxt;
    logic                 r_buzzer, w_buzzer_nxt;

    assign w_clr = ~reset | ~power_state;
    assign w_rise = cleaning_reminder & ~r_rem_q;

    always_comb begin
        w_target  = 8'd0;
        w_gear    = 4'b0000;
        w_illegal = 1'b0;
        case (mode)
            3'b000: ;
            3'b001: begin w_target = DUTY_1;     w_gear = 4'b0001; end
            3'b010: begin w_target = DUTY_2;     w_gear = 4'b0010; end
            3'b100: begin w_target = DUTY_3;     w_gear = 4'b0100; end
            3'b111: begin w_target = DUTY_CLEAN; w_gear = 4'b1000; end
            default: w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_duty      <= 8'd0;
            r_ramp_cnt  <= '0;
            r_pre_cnt   <= '0;
            r_pwm_cnt   <= 8'd0;
            r_fan_pwm   <= 1'b0;
            r_gear_led  <= 4'b0000;
            r_mode_err  <= 1'b0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_cd_led    <= 1'b0;
            r_rem_q     <= 1'b0;
        end else begin
            r_gear_led <= w_gear;
            r_mode_err <= w_illegal;
            r_rem_q    <= cleaning_reminder;

            // Free-running ramp tick; a target change only affects direction.
            if (r_ramp_cnt == c_RAMP_LAST) begin
                r_ramp_cnt <= '0;
                if (r_duty < w_target) begin
                    r_duty <= r_duty + 8'd1;
                end else if (r_duty > w_target) begin
                    r_duty <= r_duty - 8'd1;
                end
            end else begin
                r_ramp_cnt <= r_ramp_cnt + c_RAMP_W'(1);
            end

            if (r_pre_cnt == c_PRE_LAST) begin
                r_pre_cnt <= '0;
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
            end else begin
                r_pre_cnt <= r_pre_cnt + c_PRE_W'(1);
            end
            r_fan_pwm <= (r_duty == 8'hFF) || (r_pwm_cnt < r_duty);

            if (!countdown) begin
                r_blink_cnt <= '0;
                r_phase     <= 1'b1;
                r_cd_led    <= 1'b0;
            end else begin
                r_cd_led <= r_phase;
                if (r_blink_cnt == c_BLINK_LAST) begin
                    r_blink_cnt <= '0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + c_BLINK_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_state  <= S_IDLE;
            r_beep_n <= '0;
            r_tmr    <= '0;
            r_tone   <= '0;
            r_buzzer <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_beep_n <= w_beep_n_nxt;
            r_tmr    <= w_tmr_nxt;
            r_tone   <= w_tone_nxt;
            r_buzzer <= w_buzzer_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_beep_n_nxt = r_beep_n;
        w_tmr_nxt    = r_tmr;
        w_tone_nxt   = r_tone;
        w_buzzer_nxt = r_buzzer;
        // A dropped reminder silences the alert from any state.
        if (!cleaning_reminder) begin
            w_state_nxt  = S_IDLE;
            w_buzzer_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_buzzer_nxt = 1'b0;
                    if (w_rise) begin
                        w_state_nxt  = S_ON;
                        w_beep_n_nxt = '0;
                        w_tmr_nxt    = '0;
                        w_tone_nxt   = '0;
                    end
                end
                S_ON: begin
                    if (r_tmr == c_ON_LAST) begin
                        w_state_nxt  = S_OFF;
                        w_buzzer_nxt = 1'b0;
                        w_tmr_nxt    = '0;
                    end else begin
                        w_tmr_nxt = r_tmr + c_TMR_W'(1);
                        if (r_tone == c_TONE_LAST) begin
                            w_tone_nxt   = '0;
                            w_buzzer_nxt = ~r_buzzer;
                        end else begin
                            w_tone_nxt = r_tone + c_TONE_W'(1);
                        end
                    end
                end
                S_OFF: begin
                    w_buzzer_nxt = 1'b0;
                    if (r_tmr == c_OFF_LAST) begin
                        w_tmr_nxt    = '0;
                        w_beep_n_nxt = r_beep_n + c_BN_W'(1);
                        if (w_beep_n_nxt == c_BEEP_TOT) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_ON;
                            w_tone_nxt  = '0;
                        end
                    end else begin
                        w_tmr_nxt = r_tmr + c_TMR_W'(1);
                    end
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_buzzer_nxt = 1'b0;
                end
            endcase
        end
    end

    assign fan_pwm       = r_fan_pwm;
    assign fan_duty      = r_duty;
    assign gear_led      = r_gear_led;
    assign countdown_led = r_cd_led;
    assign remind_led    = r_rem_q;
    assign buzzer        = r_buzzer;
    assign mode_err      = r_mode_err;

endmodule
`default_nettype wire

// File: tb/tb_hood_output_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_hood_output_driver
// Brief    : Self-checking bench for hood_output_driver with reduced timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hood_output_driver;

    localparam int PS   = 1;
    localparam int RT   = 2;
    localparam int BH   = 4;
    localparam int TH   = 2;
    localparam int BON  = 8;
    localparam int BOFF = 4;
    localparam int BC   = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       power_state;
    logic [2:0] mode;
    logic       countdown;
    logic       cleaning_reminder;
    logic       fan_pwm;
    logic [7:0] fan_duty;
    logic [3:0] gear_led;
    logic       countdown_led;
    logic       remind_led;
    logic       buzzer;
    logic       mode_err;

    always #5 clk = ~clk;

    hood_output_driver #(
        .PWM_PRESCALE(PS), .RAMP_TICK(RT), .BLINK_HALF(BH), .TONE_HALF(TH),
        .BEEP_ON(BON), .BEEP_OFF(BOFF), .BEEP_COUNT(BC)
    ) dut (
        .clk(clk), .reset(reset), .power_state(power_state), .mode(mode),
        .countdown(countdown), .cleaning_reminder(cleaning_reminder),
        .fan_pwm(fan_pwm), .fan_duty(fan_duty), .gear_led(gear_led),
        .countdown_led(countdown_led), .remind_led(remind_led),
        .buzzer(buzzer), .mode_err(mode_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outputs derived from elapsed cycles since the last clear.
    bit m_started = 1'b0;
    int m_t, m_duty, m_gear, m_cd_n, m_bt;
    bit m_pwm, m_err, m_cd_led, m_cd_p0, m_rem_q, m_active, m_buz;

    function automatic int tgt_of(input logic [2:0] m);
        case (m)
            3'b001:  return 85;
            3'b010:  return 170;
            3'b100:  return 255;
            3'b111:  return 128;
            default: return 0;
        endcase
    endfunction

    function automatic int gear_of(input logic [2:0] m);
        case (m)
            3'b001:  return 1;
            3'b010:  return 2;
            3'b100:  return 4;
            3'b111:  return 8;
            default: return 0;
        endcase
    endfunction

    function automatic bit tone_at(input int t);
        int p;
        p = t % (BON + BOFF);
        return (p < BON) ? (((p / TH) % 2) == 1) : 1'b0;
    endfunction

    always @(posedge clk) begin
        m_started = 1'b1;
        if (!reset || !power_state) begin
            m_t = 0; m_duty = 0; m_gear = 0; m_cd_n = 0; m_bt = 0;
            m_pwm = 0; m_err = 0; m_cd_led = 0; m_cd_p0 = 0;
            m_rem_q = 0; m_active = 0; m_buz = 0;
        end else begin
            m_pwm = (m_duty == 255) || (((m_t / PS) % 256) < m_duty);
            if ((m_t % RT) == RT - 1) begin
                if (m_duty < tgt_of(mode)) m_duty++;
                else if (m_duty > tgt_of(mode)) m_duty--;
            end
            m_t++;
            m_gear = gear_of(mode);
            m_err  = (gear_of(mode) == 0) && (mode != 3'b000);
            if (!countdown) begin
                m_cd_n = 0; m_cd_p0 = 1; m_cd_led = 0;
            end else begin
                m_cd_led = (((m_cd_n / BH) % 2) == 0) ? m_cd_p0 : !m_cd_p0;
                m_cd_n++;
            end
            if (!cleaning_reminder) begin
                m_active = 0; m_buz = 0;
            end else if (m_active) begin
                m_bt++;
                if (m_bt >= BC * (BON + BOFF)) begin
                    m_active = 0; m_buz = 0;
                end else begin
                    m_buz = tone_at(m_bt);
                end
            end else if (!m_rem_q) begin
                m_active = 1; m_bt = 0; m_buz = 0;
            end else begin
                m_buz = 0;
            end
            m_rem_q = cleaning_reminder;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("fan_pwm",       32'(fan_pwm),       32'(m_pwm));
            check("fan_duty",      32'(fan_duty),      m_duty);
            check("gear_led",      32'(gear_led),      m_gear);
            check("countdown_led", 32'(countdown_led), 32'(m_cd_led));
            check("remind_led",    32'(remind_led),    32'(m_rem_q));
            check("buzzer",        32'(buzzer),        32'(m_buz));
            check("mode_err",      32'(mode_err),      32'(m_err));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_duty(input int val, input int lim);
        int k;
        k = 0;
        while (fan_duty !== 8'(val) && k < lim) begin
            cyc();
            k++;
        end
        check("wait_duty_reached", 32'(fan_duty), val);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pwm"},  32'(fan_pwm),       0);
        check({tag, "_duty"}, 32'(fan_duty),      0);
        check({tag, "_gear"}, 32'(gear_led),      0);
        check({tag, "_cd"},   32'(countdown_led), 0);
        check({tag, "_rem"},  32'(remind_led),    0);
        check({tag, "_buz"},  32'(buzzer),        0);
        check({tag, "_err"},  32'(mode_err),      0);
    endtask

    initial begin
        int cnt;
        logic [15:0] pat;
        logic [2:0] modes [0:7];

        reset = 1'b0; power_state = 1'b1; mode = 3'b000;
        countdown = 1'b0; cleaning_reminder = 1'b0;
        repeat (3) cyc();
        check_all_zero("reset");

        // Reset in the middle of a ramp, then ramp from 0 to gear 2.
        reset = 1'b1; mode = 3'b010;
        repeat (100) cyc();
        reset = 1'b0;
        cyc();
        check_all_zero("reset_mid");
        reset = 1'b1;
        repeat (340) cyc();
        check("duty_170_after_340", 32'(fan_duty), 170);

        mode = 3'b100;
        wait_duty(255, 400);
        cnt = 0;
        repeat (256) begin cyc(); cnt += int'(fan_pwm); end
        check("pwm_high_at_255", cnt, 256);

        power_state = 1'b0;
        cyc();
        check("power_off_duty", 32'(fan_duty), 0);
        power_state = 1'b1; mode = 3'b100;
        wait_duty(200, 600);
        mode = 3'b000;
        repeat (410) cyc();
        check("duty_down_to_0", 32'(fan_duty), 0);
        cnt = 0;
        repeat (256) begin cyc(); cnt += int'(fan_pwm); end
        check("pwm_high_at_0", cnt, 0);

        mode = 3'b001;
        wait_duty(85, 300);
        cnt = 0;
        repeat (256) begin cyc(); cnt += int'(fan_pwm); end
        check("pwm_high_at_85", cnt, 85);

        mode = 3'b011;
        cyc();
        check("illegal_err", 32'(mode_err), 1);
        check("illegal_gear", 32'(gear_led), 0);
        repeat (5) cyc();

        mode = 3'b001; countdown = 1'b1;
        pat = 16'b1111000011110000;
        for (int i = 0; i < 16; i++) begin
            cyc();
            check("cd_blink", 32'(countdown_led), 32'(pat[15-i]));
        end
        countdown = 1'b0;
        cyc();
        check("cd_off", 32'(countdown_led), 0);

        // Full alert: three bursts each holding the buzzer high for 4 cycles.
        cleaning_reminder = 1'b1;
        cnt = 0;
        repeat (50) begin cyc(); cnt += int'(buzzer); end
        check("alert_high_cycles", cnt, 12);
        check("remind_led_on", 32'(remind_led), 1);
        cleaning_reminder = 1'b0;
        repeat (3) cyc();
        cleaning_reminder = 1'b1;
        repeat (16) cyc();
        check("burst2_tone", 32'(buzzer), 1);
        cleaning_reminder = 1'b0;
        cyc();
        check("abort_buzzer", 32'(buzzer), 0);
        cnt = 0;
        repeat (40) begin cyc(); cnt += int'(buzzer); end
        check("no_third_burst", cnt, 0);

        modes[0] = 3'b000; modes[1] = 3'b001; modes[2] = 3'b010; modes[3] = 3'b100;
        modes[4] = 3'b111; modes[5] = 3'b011; modes[6] = 3'b101; modes[7] = 3'b110;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 2) mode = modes[$urandom_range(0, 7)];
            if ($urandom_range(0, 99) < 3) countdown = ~countdown;
            if ($urandom_range(0, 99) < 2) cleaning_reminder = ~cleaning_reminder;
            power_state = ($urandom_range(0, 499) != 0);
            reset       = ($urandom_range(0, 799) != 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
